flag_status_table: RTL and testbench

FLAG_STATUS_TABLE -- requirements
Module: flag_status_table

---
 rtl/flag_status_table.sv | 88 ++++++++
 tb/tb_flag_status_table.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/flag_status_table.sv
// Renamed condition-flag status table: per-flag ready/tag/speculative value
// tracking with CDB wakeup, plus committed flags used for mispredict recovery.
module flag_status_table #(
  parameter int TAG_W     = 3,
  parameter int NUM_FLAGS = 4,
  parameter int CDB_PORTS = 2
) (
  input  logic                           CLK,
  input  logic                           Reset,
  input  logic                           append,
  input  logic [NUM_FLAGS-1:0]           S_mask,
  input  logic [TAG_W-1:0]               ROBTail,
  input  logic [CDB_PORTS-1:0]           cdb_valid,
  input  logic [CDB_PORTS*TAG_W-1:0]     cdb_tag,
  input  logic [CDB_PORTS*NUM_FLAGS-1:0] cdb_flags,
  input  logic                           commit_valid,
  input  logic [NUM_FLAGS-1:0]           commit_mask,
  input  logic [NUM_FLAGS-1:0]           commit_flags,
  input  logic                           flush,
  output logic [NUM_FLAGS-1:0]           FlagReady,
  output logic [NUM_FLAGS*TAG_W-1:0]     index,
  output logic [NUM_FLAGS-1:0]           flag_value,
  output logic [NUM_FLAGS-1:0]           arch_flags
);

  logic [NUM_FLAGS-1:0]       r_ready;
  logic [NUM_FLAGS*TAG_W-1:0] r_tag;
  logic [NUM_FLAGS-1:0]       r_value;
  logic [NUM_FLAGS-1:0]       r_arch;

  logic [NUM_FLAGS-1:0]       w_ready_next;
  logic [NUM_FLAGS*TAG_W-1:0] w_tag_next;
  logic [NUM_FLAGS-1:0]       w_value_next;
  logic [NUM_FLAGS-1:0]       w_arch_next;

  // Committed flags after merging this cycle's retirement; flush restores from this.
  always_comb begin
    w_arch_next = r_arch;
    if (commit_valid) begin
      w_arch_next = (r_arch & ~commit_mask) | (commit_flags & commit_mask);
    end
  end

  // Ports are scanned from highest to lowest so the lowest-numbered match wins.
  always_comb begin
    w_ready_next = r_ready;
    w_tag_next   = r_tag;
    w_value_next = r_value;
    for (int f = 0; f < NUM_FLAGS; f++) begin
      if (append && S_mask[f]) begin
        w_ready_next[f]                 = 1'b0;
        w_tag_next[f*TAG_W +: TAG_W]    = ROBTail;
      end else if (!r_ready[f]) begin
        for (int p = CDB_PORTS - 1; p >= 0; p--) begin
          if (cdb_valid[p] && (cdb_tag[p*TAG_W +: TAG_W] == r_tag[f*TAG_W +: TAG_W])) begin
            w_ready_next[f] = 1'b1;
            w_value_next[f] = cdb_flags[p*NUM_FLAGS + f];
          end
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_ready <= '1;
      r_tag   <= '0;
      r_value <= '0;
      r_arch  <= '0;
    end else begin
      r_arch <= w_arch_next;
      if (flush) begin
        r_ready <= '1;
        r_value <= w_arch_next;
      end else begin
        r_ready <= w_ready_next;
        r_tag   <= w_tag_next;
        r_value <= w_value_next;
      end
    end
  end

  assign FlagReady  = r_ready;
  assign index      = r_tag;
  assign flag_value = r_value;
  assign arch_flags = r_arch;

endmodule

// File: tb/tb_flag_status_table.sv
// Bench for flag_status_table: directed scenarios followed by random traffic,
// each cycle compared against a per-flag array model of the table.
module tb_flag_status_table;

  localparam int TAG_W     = 3;
  localparam int NUM_FLAGS = 4;
  localparam int CDB_PORTS = 2;
  localparam int OUT_W     = 3 * NUM_FLAGS + NUM_FLAGS * TAG_W;

  logic                           CLK;
  logic                           Reset;
  logic                           append;
  logic [NUM_FLAGS-1:0]           S_mask;
  logic [TAG_W-1:0]               ROBTail;
  logic [CDB_PORTS-1:0]           cdb_valid;
  logic [CDB_PORTS*TAG_W-1:0]     cdb_tag;
  logic [CDB_PORTS*NUM_FLAGS-1:0] cdb_flags;
  logic                           commit_valid;
  logic [NUM_FLAGS-1:0]           commit_mask;
  logic [NUM_FLAGS-1:0]           commit_flags;
  logic                           flush;
  logic [NUM_FLAGS-1:0]           FlagReady;
  logic [NUM_FLAGS*TAG_W-1:0]     index;
  logic [NUM_FLAGS-1:0]           flag_value;
  logic [NUM_FLAGS-1:0]           arch_flags;

  flag_status_table #(
    .TAG_W(TAG_W), .NUM_FLAGS(NUM_FLAGS), .CDB_PORTS(CDB_PORTS)
  ) dut (
    .CLK(CLK), .Reset(Reset), .append(append), .S_mask(S_mask), .ROBTail(ROBTail),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_flags(cdb_flags),
    .commit_valid(commit_valid), .commit_mask(commit_mask), .commit_flags(commit_flags),
    .flush(flush), .FlagReady(FlagReady), .index(index), .flag_value(flag_value),
    .arch_flags(arch_flags)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  // reference model: one entry per flag
  bit m_ready [NUM_FLAGS];
  int m_tag   [NUM_FLAGS];
  bit m_val   [NUM_FLAGS];
  bit m_arch  [NUM_FLAGS];

  logic [OUT_W-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit new_arch [NUM_FLAGS];
    if (Reset) begin
      for (int f = 0; f < NUM_FLAGS; f++) begin
        m_ready[f] = 1'b1; m_tag[f] = 0; m_val[f] = 1'b0; m_arch[f] = 1'b0;
      end
      return;
    end
    for (int f = 0; f < NUM_FLAGS; f++) begin
      new_arch[f] = m_arch[f];
      if (commit_valid && commit_mask[f]) new_arch[f] = commit_flags[f];
    end
    for (int f = 0; f < NUM_FLAGS; f++) begin
      if (flush) begin
        m_ready[f] = 1'b1;
        m_val[f]   = new_arch[f];
      end else if (append && S_mask[f]) begin
        m_ready[f] = 1'b0;
        m_tag[f]   = int'(ROBTail);
      end else if (!m_ready[f]) begin
        int hit;
        hit = -1;
        for (int p = 0; p < CDB_PORTS; p++) begin
          if (hit < 0 && cdb_valid[p] && int'(cdb_tag[p*TAG_W +: TAG_W]) == m_tag[f]) hit = p;
        end
        if (hit >= 0) begin
          m_ready[f] = 1'b1;
          m_val[f]   = cdb_flags[hit*NUM_FLAGS + f];
        end
      end
    end
    for (int f = 0; f < NUM_FLAGS; f++) m_arch[f] = new_arch[f];
  endtask

  function automatic logic [OUT_W-1:0] model_outputs();
    logic [NUM_FLAGS-1:0]       er, ev, ea;
    logic [NUM_FLAGS*TAG_W-1:0] ei;
    for (int f = 0; f < NUM_FLAGS; f++) begin
      er[f] = m_ready[f];
      ev[f] = m_val[f];
      ea[f] = m_arch[f];
      ei[f*TAG_W +: TAG_W] = TAG_W'(m_tag[f]);
    end
    return {er, ei, ev, ea};
  endfunction

  // driver tasks
  task automatic drive_idle();
    Reset = 1'b0; append = 1'b0; S_mask = '0; ROBTail = '0;
    cdb_valid = '0; cdb_tag = '0; cdb_flags = '0;
    commit_valid = 1'b0; commit_mask = '0; commit_flags = '0; flush = 1'b0;
  endtask

  task automatic drive_cdb(input int p, input int tag, input logic [NUM_FLAGS-1:0] flags);
    cdb_valid[p] = 1'b1;
    cdb_tag[p*TAG_W +: TAG_W] = TAG_W'(tag);
    cdb_flags[p*NUM_FLAGS +: NUM_FLAGS] = flags;
  endtask

  // one clock: model follows the driven inputs, scoreboard compares after the edge
  task automatic cycle();
    logic [OUT_W-1:0] exp;
    @(posedge CLK);
    model_step();
    exp_q.push_back(model_outputs());
    #1;
    exp = exp_q.pop_front();
    chk("model", 32'({FlagReady, index, flag_value, arch_flags}), 32'(exp));
  endtask

  initial begin
    drive_idle();
    for (int f = 0; f < NUM_FLAGS; f++) begin
      m_ready[f] = 1'b0; m_tag[f] = 0; m_val[f] = 1'b0; m_arch[f] = 1'b0;
    end

    // reset state
    Reset = 1'b1; cycle(); cycle(); drive_idle();
    chk("reset_ready", 32'(FlagReady), 32'hF);
    chk("reset_index", 32'(index), 32'h0);
    chk("reset_value", 32'(flag_value), 32'h0);
    chk("reset_arch", 32'(arch_flags), 32'h0);

    // append two flags, resolve them from port 1
    append = 1'b1; S_mask = 4'b0011; ROBTail = 3'd5; cycle(); drive_idle();
    chk("append_ready", 32'(FlagReady), 32'hC);
    chk("append_index", 32'(index), 32'h02D);
    drive_cdb(1, 5, 4'b0010); cycle(); drive_idle();
    chk("cdb_p1_ready", 32'(FlagReady), 32'hF);
    chk("cdb_p1_value", 32'(flag_value), 32'h2);

    // append beats same-cycle CDB match on the same flag
    append = 1'b1; S_mask = 4'b1111; ROBTail = 3'd2; cycle(); drive_idle();
    append = 1'b1; S_mask = 4'b0001; ROBTail = 3'd6; drive_cdb(0, 2, 4'b1110); cycle(); drive_idle();
    chk("append_prio_ready", 32'(FlagReady), 32'hE);
    chk("append_prio_tag0", 32'(index[2:0]), 32'd6);
    chk("append_prio_value", 32'(flag_value), 32'hE);

    // two ports match: lowest port wins
    append = 1'b1; S_mask = 4'b0100; ROBTail = 3'd3; cycle(); drive_idle();
    drive_cdb(0, 3, 4'b1111); drive_cdb(1, 3, 4'b0000); cycle(); drive_idle();
    chk("port_prio_value2", 32'(flag_value[2]), 32'd1);
    drive_cdb(1, 6, 4'b0000); cycle(); drive_idle();
    chk("flag0_resolved", 32'(FlagReady), 32'hF);

    // flush with same-cycle commit
    append = 1'b1; S_mask = 4'b1111; ROBTail = 3'd1; cycle(); drive_idle();
    chk("all_pending", 32'(FlagReady), 32'h0);
    commit_valid = 1'b1; commit_mask = 4'b1000; commit_flags = 4'b1000; flush = 1'b1;
    cycle(); drive_idle();
    chk("flush_ready", 32'(FlagReady), 32'hF);
    chk("flush_value", 32'(flag_value), 32'h8);
    chk("flush_arch", 32'(arch_flags), 32'h8);

    // reset discards pending state; stale CDB is ignored
    append = 1'b1; S_mask = 4'b0010; ROBTail = 3'd7; cycle(); drive_idle();
    Reset = 1'b1; cycle(); drive_idle();
    drive_cdb(0, 7, 4'b1111); cycle(); drive_idle();
    chk("post_reset_ready", 32'(FlagReady), 32'hF);
    chk("post_reset_value", 32'(flag_value), 32'h0);

    // CDB match on already-ready flags changes nothing
    append = 1'b1; S_mask = 4'b1111; ROBTail = 3'd4; cycle(); drive_idle();
    drive_cdb(0, 4, 4'b1010); cycle(); drive_idle();
    drive_cdb(0, 4, 4'b0101); cycle(); drive_idle();
    chk("ready_ignore_value", 32'(flag_value), 32'hA);
    chk("ready_ignore_ready", 32'(FlagReady), 32'hF);
    chk("ready_ignore_index", 32'(index), 32'h924);

    // idle hold
    cycle(); cycle();
    chk("hold_value", 32'(flag_value), 32'hA);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      drive_idle();
      Reset        = ($urandom_range(0, 63) == 0);
      append       = ($urandom_range(0, 1) == 1);
      S_mask       = 4'($urandom_range(0, 15));
      ROBTail      = 3'($urandom_range(0, 7));
      cdb_valid    = 2'($urandom_range(0, 3));
      cdb_tag      = 6'($urandom_range(0, 63));
      cdb_flags    = 8'($urandom_range(0, 255));
      commit_valid = ($urandom_range(0, 3) == 0);
      commit_mask  = 4'($urandom_range(0, 15));
      commit_flags = 4'($urandom_range(0, 15));
      flush        = ($urandom_range(0, 15) == 0);
      cycle();
    end
    drive_idle();
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
